// File: rtl/uart_pkg.sv
// Definitions shared by the UART blocks: issue FSM state encoding,
// default line settings and byte width.
package uart_pkg;

    localparam int BYTE_W     = 8;
    localparam int BAUDRATE   = 115200;
    localparam int CLOCK_FREQ = 27000000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with count-based full/empty and a synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_wr;
    logic              w_rd;

    assign o_full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Flush wins over both a same-cycle write and pop.
    assign w_wr = i_wr_en && !o_full && !i_flush;
    assign w_rd = i_rd_en && !o_empty && !i_flush;

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter; issues one byte per
// tx_start pulse and declares it lost if tx_busy never answers.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic [ADDR_W:0]   count,
    output logic              idle,
    output logic              err_lost
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_tmo_cnt;
    logic              r_tx_start;
    logic              r_err_lost;
    logic [BYTE_W-1:0] r_tx_data;
    logic [BYTE_W-1:0] w_rd_data;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_timeout;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_flush   (flush),
        .i_wr_en   (in_valid),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_count   (count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign in_ready = !w_full;
    assign idle     = w_empty && (r_state == ST_IDLE) && !tx_busy;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign err_lost = r_err_lost;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !tx_busy && !flush) begin
                    w_state_nxt = ST_ISSUE;
                    w_pop       = 1'b1;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_tmo_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_err_lost <= 1'b0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= w_pop;
            r_err_lost <= w_timeout;
            if (w_pop) r_tx_data <= w_rd_data;
            // Counter only runs while waiting for the transmitter to answer.
            if (r_state == ST_WAIT_BUSY && !tx_busy) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else                                     r_tmo_cnt <= '0;
        end
    end

endmodule
